// File: rtl/sc_regshifter_flags.sv
// Output register with load/shift and registered active-low ALU flags (N, Z, C, V).
// Define SC_REGSHIFTER_FLAGS_ASR_EN for arithmetic shift right; otherwise shift right is logical.
module sc_regshifter_flags #(
  parameter int DATAWIDTH_BUS                  = 8,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2
) (
  input  logic                                      SC_REGSHIFTER_FLAGS_CLOCK_50,
  input  logic                                      SC_REGSHIFTER_FLAGS_Reset_InLow,
  input  logic [DATAWIDTH_BUS-1:0]                  SC_REGSHIFTER_FLAGS_Data_In,
  input  logic                                      SC_REGSHIFTER_FLAGS_Load_InLow,
  input  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_REGSHIFTER_FLAGS_ShiftSelection_In,
  input  logic                                      SC_REGSHIFTER_FLAGS_ALUCarry_InHigh,
  input  logic                                      SC_REGSHIFTER_FLAGS_ALUOverflow_InHigh,
  output logic [DATAWIDTH_BUS-1:0]                  SC_REGSHIFTER_FLAGS_Data_Out,
  output logic                                      SC_REGSHIFTER_FLAGS_Overflow_OutLow,
  output logic                                      SC_REGSHIFTER_FLAGS_Carry_OutLow,
  output logic                                      SC_REGSHIFTER_FLAGS_Negative_OutLow,
  output logic                                      SC_REGSHIFTER_FLAGS_Zero_OutLow
);

  localparam int W = DATAWIDTH_BUS;
  localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SEL_LEFT  = DATAWIDTH_REGSHIFTER_SELECTION'(1);
  localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SEL_RIGHT = DATAWIDTH_REGSHIFTER_SELECTION'(2);

  logic [W-1:0] r_data;
  logic         r_overflow_low;
  logic         r_carry_low;
  logic         r_negative_low;
  logic         r_zero_low;

  logic [W-1:0] w_data_next;
  logic         w_carry_next;
  logic         w_overflow_next;
  logic         w_update;
  logic         w_fill;

`ifdef SC_REGSHIFTER_FLAGS_ASR_EN
  assign w_fill = r_data[W-1];
`else
  assign w_fill = 1'b0;
`endif

  // Load beats shift; a hold leaves w_update low so the registers keep their values.
  always_comb begin
    w_data_next     = r_data;
    w_carry_next    = 1'b0;
    w_overflow_next = 1'b0;
    w_update        = 1'b0;
    if (!SC_REGSHIFTER_FLAGS_Load_InLow) begin
      w_data_next     = SC_REGSHIFTER_FLAGS_Data_In;
      w_carry_next    = SC_REGSHIFTER_FLAGS_ALUCarry_InHigh;
      w_overflow_next = SC_REGSHIFTER_FLAGS_ALUOverflow_InHigh;
      w_update        = 1'b1;
    end else if (SC_REGSHIFTER_FLAGS_ShiftSelection_In == SEL_LEFT) begin
      w_data_next     = {r_data[W-2:0], 1'b0};
      w_carry_next    = r_data[W-1];
      w_overflow_next = r_data[W-1] ^ r_data[W-2];
      w_update        = 1'b1;
    end else if (SC_REGSHIFTER_FLAGS_ShiftSelection_In == SEL_RIGHT) begin
      w_data_next     = {w_fill, r_data[W-1:1]};
      w_carry_next    = r_data[0];
      w_overflow_next = 1'b0;
      w_update        = 1'b1;
    end
  end

  // Flags are stored already inverted so every output is a plain register bit.
  always_ff @(posedge SC_REGSHIFTER_FLAGS_CLOCK_50) begin
    if (!SC_REGSHIFTER_FLAGS_Reset_InLow) begin
      r_data         <= '0;
      r_overflow_low <= 1'b1;
      r_carry_low    <= 1'b1;
      r_negative_low <= 1'b1;
      r_zero_low     <= 1'b0;
    end else if (w_update) begin
      r_data         <= w_data_next;
      r_overflow_low <= ~w_overflow_next;
      r_carry_low    <= ~w_carry_next;
      r_negative_low <= ~w_data_next[W-1];
      r_zero_low     <= |w_data_next;
    end
  end

  assign SC_REGSHIFTER_FLAGS_Data_Out         = r_data;
  assign SC_REGSHIFTER_FLAGS_Overflow_OutLow  = r_overflow_low;
  assign SC_REGSHIFTER_FLAGS_Carry_OutLow     = r_carry_low;
  assign SC_REGSHIFTER_FLAGS_Negative_OutLow  = r_negative_low;
  assign SC_REGSHIFTER_FLAGS_Zero_OutLow      = r_zero_low;

endmodule

// File: tb/tb_sc_regshifter_flags.sv
// Bench for sc_regshifter_flags (W=8): directed cases plus randomized traffic against an arithmetic model.
module tb_sc_regshifter_flags;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       ld_n;
  logic [1:0] sel;
  logic       ci;
  logic       vi;
  logic [7:0] dout;
  logic       ovl, cyl, ngl, zrl;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: value as an integer 0..255, carry and overflow as bits; N and Z follow from the value.
  int m_data = 0;
  bit m_c    = 0;
  bit m_v    = 0;

`ifdef SC_REGSHIFTER_FLAGS_ASR_EN
  localparam bit ASR = 1'b1;
`else
  localparam bit ASR = 1'b0;
`endif

  always #5 clk = ~clk;

  sc_regshifter_flags dut (
    .SC_REGSHIFTER_FLAGS_CLOCK_50          (clk),
    .SC_REGSHIFTER_FLAGS_Reset_InLow       (rst_n),
    .SC_REGSHIFTER_FLAGS_Data_In           (din),
    .SC_REGSHIFTER_FLAGS_Load_InLow        (ld_n),
    .SC_REGSHIFTER_FLAGS_ShiftSelection_In (sel),
    .SC_REGSHIFTER_FLAGS_ALUCarry_InHigh   (ci),
    .SC_REGSHIFTER_FLAGS_ALUOverflow_InHigh(vi),
    .SC_REGSHIFTER_FLAGS_Data_Out          (dout),
    .SC_REGSHIFTER_FLAGS_Overflow_OutLow   (ovl),
    .SC_REGSHIFTER_FLAGS_Carry_OutLow      (cyl),
    .SC_REGSHIFTER_FLAGS_Negative_OutLow   (ngl),
    .SC_REGSHIFTER_FLAGS_Zero_OutLow       (zrl)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge: advance the model with the applied inputs, then compare every output.
  task automatic step(input string tag);
    int nv;
    @(posedge clk);
    if (!rst_n) begin
      m_data = 0; m_c = 0; m_v = 0;
    end else if (!ld_n) begin
      m_data = int'(din); m_c = ci; m_v = vi;
    end else if (sel == 2'd1) begin
      nv     = (m_data * 2) % 256;
      m_c    = (m_data >= 128);
      m_v    = ((m_data >= 128) != (nv >= 128));  // sign changed => signed overflow
      m_data = nv;
    end else if (sel == 2'd2) begin
      m_c    = (m_data % 2) == 1;
      m_v    = 1'b0;
      nv     = m_data / 2;
      if (ASR && m_data >= 128) nv = nv + 128;
      m_data = nv;
    end
    #1;
    check({tag, ".data"}, 32'(dout), 32'(m_data));
    check({tag, ".zl"},   32'(zrl),  32'(m_data != 0));
    check({tag, ".nl"},   32'(ngl),  32'(m_data < 128));
    check({tag, ".cl"},   32'(cyl),  32'(!m_c));
    check({tag, ".vl"},   32'(ovl),  32'(!m_v));
    $display("[TB] %s: rst_n=%0b ld_n=%0b sel=%0d din=0x%02h -> dout=0x%02h vl=%0b cl=%0b nl=%0b zl=%0b",
             tag, rst_n, ld_n, sel, din, dout, ovl, cyl, ngl, zrl);
  endtask

  task automatic load(input logic [7:0] v, input logic c, input logic o, input string tag);
    ld_n = 1'b0; sel = 2'd0; din = v; ci = c; vi = o;
    step(tag);
    ld_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; ld_n = 1'b1; sel = 2'd0; din = 8'h00; ci = 1'b0; vi = 1'b0;
    #2;

    // Reset wins over a simultaneous load.
    rst_n = 1'b0; ld_n = 1'b0; din = 8'h55;
    step("reset");
    check("reset.data_const", 32'(dout), 32'h00);
    check("reset.zl_const",   32'(zrl),  32'd0);
    check("reset.nl_const",   32'(ngl),  32'd1);
    rst_n = 1'b1; ld_n = 1'b1;

    load(8'hF3, 1'b1, 1'b0, "load_f3");
    check("load_f3.data_const", 32'(dout), 32'hF3);
    check("load_f3.cl_const",   32'(cyl),  32'd0);

    load(8'hC1, 1'b0, 1'b0, "load_c1");
    sel = 2'd1; step("shl1");
    check("shl1.data_const", 32'(dout), 32'h82);
    check("shl1.vl_const",   32'(ovl),  32'd1);
    step("shl2");
    check("shl2.data_const", 32'(dout), 32'h04);
    check("shl2.vl_const",   32'(ovl),  32'd0);
    sel = 2'd0;

    load(8'h81, 1'b0, 1'b1, "load_81");
    sel = 2'd2; step("shr");
    check("shr.data_const", 32'(dout), ASR ? 32'hC0 : 32'h40);
    check("shr.cl_const",   32'(cyl),  32'd0);
    sel = 2'd0;

    // Load and shift in the same cycle: the load wins.
    load(8'h7F, 1'b0, 1'b0, "load_7f");
    ld_n = 1'b0; sel = 2'd1; din = 8'h00; ci = 1'b1; vi = 1'b1;
    step("load_vs_shl");
    check("load_vs_shl.data_const", 32'(dout), 32'h00);
    check("load_vs_shl.vl_const",   32'(ovl),  32'd0);
    ld_n = 1'b1; sel = 2'd0;

    load(8'h80, 1'b0, 1'b1, "load_80");
    sel = 2'd3;
    for (int i = 0; i < 3; i++) step("hold11");
    check("hold.data_const", 32'(dout), 32'h80);
    sel = 2'd1; step("shl_to_zero");
    check("shl_to_zero.data_const", 32'(dout), 32'h00);
    check("shl_to_zero.zl_const",   32'(zrl),  32'd0);
    check("shl_to_zero.cl_const",   32'(cyl),  32'd0);
    sel = 2'd0;

    // Random traffic, with rare resets and loads so shift runs reach empty/full patterns.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 31) != 0);
      ld_n  = ($urandom_range(0, 3) != 0);
      sel   = 2'($urandom_range(0, 3));
      din   = 8'($urandom_range(0, 255));
      ci    = 1'($urandom_range(0, 1));
      vi    = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_regshifter_flags.md
SC_REGSHIFTER_FLAGS -- requirements
Module: SC_REGSHIFTER_FLAGS

Interface
REQ-001 The block SHALL have parameter DATAWIDTH_BUS, default 8, which sets the data register and bus width (minimum 2).
REQ-002 The block SHALL have parameter DATAWIDTH_REGSHIFTER_SELECTION, default 2, which sets the shift-select width.
REQ-003 The block SHALL have port SC_REGSHIFTER_FLAGS_CLOCK_50, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port SC_REGSHIFTER_FLAGS_Reset_InLow, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port SC_REGSHIFTER_FLAGS_Data_In, input, DATAWIDTH_BUS bits: the ALU result.
REQ-006 The block SHALL have port SC_REGSHIFTER_FLAGS_Load_InLow, input, 1 bit: 0 = load Data_In.
REQ-007 The block SHALL have port SC_REGSHIFTER_FLAGS_ShiftSelection_In, input, DATAWIDTH_REGSHIFTER_SELECTION bits: 01 = shift left, 10 = shift right, 00/11 = hold.
REQ-008 The block SHALL have ports SC_REGSHIFTER_FLAGS_ALUCarry_InHigh and SC_REGSHIFTER_FLAGS_ALUOverflow_InHigh, input, 1 bit each: ALU carry and overflow for the value on Data_In.
REQ-009 The block SHALL have port SC_REGSHIFTER_FLAGS_Data_Out, output, DATAWIDTH_BUS bits: the data register, which drives the BUSC write path.
REQ-010 The block SHALL have ports SC_REGSHIFTER_FLAGS_Overflow_OutLow, _Carry_OutLow, _Negative_OutLow and _Zero_OutLow, output, 1 bit each: the registered flags, active-low, feeding the control state machine.

Function
REQ-011 All outputs SHALL come directly from registers, with no combinational path from any input to any output.
REQ-012 Each operation SHALL be visible on the outputs on the first rising edge after its inputs are applied (latency 1 cycle).
REQ-013 Priority SHALL be reset > load > shift > hold.
REQ-014 On load, data SHALL become Data_In, C SHALL become ALUCarry_InHigh, and V SHALL become ALUOverflow_InHigh.
REQ-015 On shift left, data SHALL become {data[W-2:0],0}, C SHALL become old data[W-1], and V SHALL become old data[W-1] XOR old data[W-2].
REQ-016 On shift right, data SHALL become {fill,data[W-1:1]}, C SHALL become old data[0], V SHALL become 0, and fill SHALL be as set by REQ-024/025.
REQ-017 After every load or shift, N SHALL become the new data[W-1] and Z SHALL become 1 exactly when the new data is all zeros.
REQ-018 On hold, data and all four flags SHALL keep their values.
REQ-019 Each active-low flag output SHALL equal the inverse of its internal flag.
REQ-020 A shift that clears the register (e.g. 0x80 shifted left) SHALL set Z, with C=1.
REQ-021 Repeated shifts SHALL neither wrap around nor rotate; bits shifted out SHALL be lost except for C.
REQ-022 When Load_InLow=0 and ShiftSelection is 01 or 10 in the same cycle, the shift SHALL be ignored and the load applied.

Reset
REQ-023 When Reset_InLow=0 at a rising edge, then regardless of load and shift inputs, or of a load/shift sequence in progress:
- data SHALL become 0;
- N, C and V SHALL become 0 and Z SHALL become 1, so Zero_OutLow=0 and the other three flag outputs are 1;
- the reset values SHALL be visible on the outputs the cycle after that edge.

Configuration
REQ-024 With macro SC_REGSHIFTER_FLAGS_ASR_EN defined, shift right SHALL be arithmetic (fill = old data[W-1]).
REQ-025 Without SC_REGSHIFTER_FLAGS_ASR_EN, shift right SHALL be logical (fill = 0); all other behaviour SHALL be identical.

Verification (W=8)
REQ-026 The bench SHALL cover: Reset_InLow=0 for one edge while Load_InLow=0 with Data_In=0x55 -> Data_Out=0x00, Zero_OutLow=0, Negative/Carry/Overflow_OutLow=1.
REQ-027 The bench SHALL cover: load 0xF3 with ALUCarry=1 and ALUOverflow=0 -> Data_Out=0xF3, Negative_OutLow=0, Zero_OutLow=1, Carry_OutLow=0, Overflow_OutLow=1.
REQ-028 The bench SHALL cover: from 0xC1 shift left -> 0x82, Carry_OutLow=0, Overflow_OutLow=1; then shift left -> 0x04, Carry_OutLow=0, Overflow_OutLow=0, Negative_OutLow=1.
REQ-029 The bench SHALL cover: from 0x81 shift right -> 0xC0 with ASR_EN, 0x40 without; Carry_OutLow=0 and Overflow_OutLow=1 in both builds.
REQ-030 The bench SHALL cover: Load_InLow=0 with Data_In=0x00 and ShiftSelection=01 in the same cycle, register 0x7F -> Data_Out=0x00, Zero_OutLow=0, flags taken from the ALU inputs.
REQ-031 The bench SHALL cover: load 0x80 then three cycles with ShiftSelection=11 -> 0x80 held with flags unchanged; then shift left -> 0x00, Zero_OutLow=0, Carry_OutLow=0.
